// File: rtl/phase_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer with req/ready memory waits,
// run/stop/halt control, memory-timeout bus error and a retired-instruction counter.
module phase_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       op1,
  input  logic [3:0]       op3,
  input  logic             write_order,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic [4:0]       phase,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_err;
  logic [CNT_W-1:0]  r_ret;
  logic              r_start_low;
  logic              w_timeout;
  logic              w_wait_last;
  logic              w_is_hlt;

  assign w_wait_last = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_is_hlt    = (op1 == 2'b11) && (op3 == 4'hF);

  // Next-state decode; a wait that would reach TIMEOUT diverts to HALTED.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_IF;
      S_IF: begin
        if (mem_ready) begin
          w_next = S_ID;
        end else if (w_wait_last) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_ID:  w_next = S_EX;
      S_EX:  w_next = (op1[1] == 1'b0) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          w_next = S_WB;
        end else if (w_wait_last) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB: begin
        if (w_is_hlt)  w_next = S_HALT;
        else if (stop) w_next = S_IDLE;
        else           w_next = S_IF;
      end
      S_HALT:  if (start && r_start_low) w_next = S_IF;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_err       <= 1'b0;
      r_ret       <= '0;
      r_start_low <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= '0;
      else if ((r_state == S_IF) || (r_state == S_MEM)) r_wait <= r_wait + WAIT_W'(1);
      else r_wait <= '0;
      if (w_timeout) r_err <= 1'b1;
      if (r_state == S_WB) r_ret <= r_ret + CNT_W'(1);
      // A held start must drop once after entering HALTED before it can restart.
      if ((w_next == S_HALT) && (r_state != S_HALT)) r_start_low <= 1'b0;
      else if ((r_state == S_HALT) && !start)        r_start_low <= 1'b1;
    end
  end

  assign mem_req   = (r_state == S_IF) || (r_state == S_MEM);
  assign mem_we    = (r_state == S_MEM) && (op1 == 2'b01);
  assign ir_we     = (r_state == S_IF) && mem_ready;
  assign pc_we     = (r_state == S_WB);
  assign reg_we    = (r_state == S_WB) && write_order;
  assign halted    = (r_state == S_HALT);
  assign phase     = {r_state == S_WB, r_state == S_MEM, r_state == S_EX,
                      r_state == S_ID, r_state == S_IF};
  assign bus_error = r_err;
  assign retired   = r_ret;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer: an instruction-level planner generates
// per-cycle stimulus together with the expected strobe trace for each instruction.
module tb_phase_sequencer;

  localparam int unsigned CNT_W = 2;
  localparam int unsigned TMO   = 4;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_IF   = 5'b00001;
  localparam logic [4:0] P_ID   = 5'b00010;
  localparam logic [4:0] P_EX   = 5'b00100;
  localparam logic [4:0] P_MEM  = 5'b01000;
  localparam logic [4:0] P_WB   = 5'b10000;

  localparam int NX_IF = 0, NX_IDLE = 1, NX_HALT = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start, stop, write_order, mem_ready;
  logic [1:0]       op1;
  logic [3:0]       op3;
  logic             mem_req, mem_we, ir_we, pc_we, reg_we, halted, bus_error;
  logic [4:0]       phase;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  logic [CNT_W-1:0] m_ret;
  logic             m_err;
  logic [1:0]       p_op1;
  logic [3:0]       p_op3;
  logic             p_wo;

  phase_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .op1(op1), .op3(op3), .write_order(write_order), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .phase(phase), .halted(halted), .bus_error(bus_error),
    .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return 32'({phase, mem_req, mem_we, ir_we, pc_we, reg_we, halted, bus_error, retired});
  endfunction

  // One clock: drive inputs just after the edge, compare outputs on the falling edge.
  task automatic cyc(input logic st, input logic sp, input logic rdy, input logic [4:0] ph,
                     input logic rq, input logic we, input logic iw, input logic pw,
                     input logic rw, input logic hl, input string tag);
    @(posedge clock);
    #1;
    start = st; stop = sp; mem_ready = rdy;
    op1 = p_op1; op3 = p_op3; write_order = p_wo;
    @(negedge clock);
    cyc_n++;
    check(tag, observed(), 32'({ph, rq, we, iw, pw, rw, hl, m_err, m_ret}));
    if (pw) m_ret = m_ret + CNT_W'(1);
  endtask

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  task automatic run_idle();
    int n = int'($urandom % 3);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), P_NONE, 0, 0, 0, 0, 0, 0, "idle");
    cyc(1'b1, rb(), rb(), P_NONE, 0, 0, 0, 0, 0, 0, "idle_start");
  endtask

  task automatic run_halt();
    int h1 = int'($urandom % 3);
    int h0 = 1 + int'($urandom % 2);
    for (int i = 0; i < h1; i++) cyc(1'b1, rb(), rb(), P_NONE, 0, 0, 0, 0, 0, 1, "halt_held");
    for (int i = 0; i < h0; i++) cyc(1'b0, rb(), rb(), P_NONE, 0, 0, 0, 0, 0, 1, "halt_low");
    cyc(1'b1, rb(), rb(), P_NONE, 0, 0, 0, 0, 0, 1, "halt_start");
  endtask

  // Plays one instruction from IF; returns where the sequencer goes afterwards.
  task automatic run_instr(input bit directed, input logic [1:0] d_op1, input logic [3:0] d_op3,
                           input int d_wf, input int d_wm, input logic d_stop, output int nx);
    int wf, wm, r;
    logic sp, st_we, hlt;
    r = int'($urandom % 16);
    wf = (r == 0) ? 4 + int'($urandom % 2) : int'($urandom % 3);
    r = int'($urandom % 16);
    wm = (r == 0) ? 4 : (r < 4) ? 3 : int'($urandom % 2);
    p_op1 = 2'($urandom);
    p_op3 = (p_op1 == 2'b11 && ($urandom % 5 == 0)) ? 4'hF : 4'($urandom);
    p_wo  = rb();
    sp    = ($urandom % 4 == 0);
    if (directed) begin
      p_op1 = d_op1; p_op3 = d_op3; wf = d_wf; wm = d_wm; sp = d_stop; p_wo = 1'b1;
    end
    st_we = (p_op1 == 2'b01);
    hlt   = (p_op1 == 2'b11) && (p_op3 == 4'hF);
    for (int i = 0; i < wf && i < int'(TMO); i++)
      cyc(rb(), rb(), 1'b0, P_IF, 1, 0, 0, 0, 0, 0, "if_wait");
    if (wf >= int'(TMO)) begin
      m_err = 1'b1;
      nx = NX_HALT;
      return;
    end
    cyc(rb(), rb(), 1'b1, P_IF, 1, 0, 1, 0, 0, 0, "if_done");
    cyc(rb(), rb(), rb(), P_ID, 0, 0, 0, 0, 0, 0, "id");
    cyc(rb(), rb(), rb(), P_EX, 0, 0, 0, 0, 0, 0, "ex");
    if (p_op1[1] == 1'b0) begin
      for (int i = 0; i < wm && i < int'(TMO); i++)
        cyc(rb(), rb(), 1'b0, P_MEM, 1, st_we, 0, 0, 0, 0, "mem_wait");
      if (wm >= int'(TMO)) begin
        m_err = 1'b1;
        nx = NX_HALT;
        return;
      end
      cyc(rb(), rb(), 1'b1, P_MEM, 1, st_we, 0, 0, 0, 0, "mem_done");
    end
    cyc(rb(), sp, rb(), P_WB, 0, 0, 0, 1, p_wo, 0, "wb");
    nx = hlt ? NX_HALT : (sp ? NX_IDLE : NX_IF);
  endtask

  // From IDLE: run a store into MEM, then pull reset_n low between clock edges.
  task automatic reset_in_mem();
    p_op1 = 2'b01; p_op3 = 4'h0; p_wo = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, P_NONE, 0, 0, 0, 0, 0, 0, "rst_idle");
    cyc(1'b0, 1'b0, 1'b1, P_IF, 1, 0, 1, 0, 0, 0, "rst_if");
    cyc(1'b0, 1'b0, 1'b0, P_ID, 0, 0, 0, 0, 0, 0, "rst_id");
    cyc(1'b0, 1'b0, 1'b0, P_EX, 0, 0, 0, 0, 0, 0, "rst_ex");
    cyc(1'b0, 1'b0, 1'b0, P_MEM, 1, 1, 0, 0, 0, 0, "rst_mem");
    @(posedge clock);
    #2;
    check("rst_pre_mem_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    m_ret = '0;
    m_err = 1'b0;
    #1;
    check("rst_async", observed(), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int nx;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    op1 = '0; op3 = '0; write_order = 1'b0;
    p_op1 = '0; p_op3 = '0; p_wo = 1'b0;
    m_ret = '0; m_err = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", observed(), 32'd0);
    reset_n = 1'b1;

    // Directed: ADD, store with three waits, stop during run, then HLT with start held.
    run_idle();
    run_instr(1'b1, 2'b11, 4'h0, 0, 0, 1'b0, nx);
    check("add_next", 32'(nx), 32'(NX_IF));
    run_instr(1'b1, 2'b01, 4'h0, 0, 3, 1'b1, nx);
    run_idle();
    run_instr(1'b1, 2'b11, 4'hF, 0, 0, 1'b0, nx);
    run_halt();
    run_instr(1'b1, 2'b00, 4'h3, 5, 0, 1'b0, nx);
    run_halt();
    nx = NX_IF;

    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        if (nx == NX_HALT) run_halt();
        if (nx == NX_IDLE) run_idle();
        run_instr(1'b1, 2'b10, 4'h1, 0, 0, 1'b1, nx);
        reset_in_mem();
        nx = NX_IDLE;
      end
      if (nx == NX_IDLE) run_idle();
      else if (nx == NX_HALT) run_halt();
      run_instr(1'b0, 2'b00, 4'h0, 0, 0, 1'b0, nx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit processor core. Steps each instruction through the fetch, decode, execute, memory and writeback phases, and handles memory waits through a req/ready handshake. Gates the decoded register write order, PC update and memory write into the correct phase, and handles run/stop/halt and a memory-timeout error. Sits between the instruction-field decode (op1/op3/Ra_op2, write order) and the register file, PC and memory interface.

Parameters:
CNT_W, 16, width of the retired-instruction counter
TIMEOUT, 255, maximum wait cycles for mem_ready before a bus error (1..255)

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  level; leaves IDLE/HALTED and begins fetching
stop  input  1  level; finish the current instruction, then go to IDLE
op1  input  2  instruction bits [15:14], valid from ID onward
op3  input  4  ALU sub-op, valid from ID onward
write_order  input  1  register write permission from the write-address decoder
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request (fetch or data)
mem_we  output  1  data write (store) qualifier for mem_req
ir_we  output  1  instruction register load strobe
pc_we  output  1  PC update strobe (datapath selects the branch target)
reg_we  output  1  register file write enable
phase  output  5  one-hot {WB,MEM,EX,ID,IF}; all zero in IDLE/HALTED
halted  output  1  high in HALTED
bus_error  output  1  sticky; set on timeout
retired  output  CNT_W  count of completed instructions

Behaviour:
- The state register holds IDLE, IF, ID, EX, MEM, WB or HALTED. On reset_n low, asynchronously: state=IDLE, retired=0, bus_error=0, wait counter=0, all strobes 0.
- IDLE: if start=1 go to IF, else stay.
- IF: mem_req=1, mem_we=0. If mem_ready=1, ir_we=1 in the same cycle and go to ID. Otherwise stay in IF and increment the wait counter.
- ID: one cycle, then EX.
- EX: one cycle. Go to MEM if op1 is 00 (LD) or 01 (ST); otherwise go to WB.
- MEM: mem_req=1, and mem_we=1 if op1=01. If mem_ready=1, go to WB; otherwise wait, as in IF.
- WB, single cycle:
  - pc_we=1 and reg_we=write_order.
  - retired increments; it wraps from all-ones to 0.
  - Next state: HALTED if HLT (op1=11, op3=1111), else IDLE if stop=1, else IF.
- HALTED: halted=1 and no strobes. start=1 goes to IF, but only after start has been seen low at least once since entering HALTED; this stops a held start from re-running a halted program.
- Timeout:
  - The wait counter clears on every state change.
  - If it reaches TIMEOUT while still waiting in IF or MEM, set bus_error=1, go to HALTED and drop mem_req the next cycle.
  - bus_error clears only on reset.
- Outputs are Moore decodes of state, except ir_we, which is also qualified by mem_ready.
- reg_we and pc_we are never asserted outside WB.
- mem_req is never asserted outside IF/MEM.
- Exactly one phase bit is set in IF..WB.
- stop is sampled only in WB, so mid-instruction stop has no effect until writeback.
- start while running is ignored.
- mem_ready outside IF/MEM is ignored.
- Latency per instruction with mem_ready tied high: ALU/branch 4 cycles; LD/ST 5 cycles.

Test Plan:
- Reset with start=0 -> IDLE; phase=00000, retired=0, all strobes 0. Assert reset_n low mid-MEM -> state returns to IDLE immediately and mem_req drops without a clock.
- start=1, mem_ready=1, op1=11 op3=0000 (ADD), write_order=1 -> phase sequence IF,ID,EX,WB; ir_we in cycle 1; reg_we=pc_we=1 in cycle 4; retired=1.
- op1=01 (ST), mem_ready low for 3 cycles in MEM -> mem_req=mem_we=1 held 4 cycles, reg_we=0 in WB.
- op1=11 op3=1111 (HLT) with start held high -> HALTED, halted=1, no re-fetch. Drop start, then raise it -> IF resumes.
- mem_ready held low in IF with TIMEOUT=4 -> bus_error=1 after 4 wait cycles, HALTED, mem_req=0 thereafter.
- CNT_W=2, run 5 instructions -> retired = 1,2,3,0,1. stop asserted during EX -> instruction completes WB, then IDLE.
